// File: rtl/imm_gen_pipe.sv
// Registered immediate generator for the RV32I/RV64I decode stage: decodes immediate,
// format and illegal flag plus the PC-relative target, buffered by a 2-entry skid FIFO.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int ZICSR = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_target
);

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_Z    = 3'd6;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            illegal;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] target;
  } entry_t;

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

  function automatic logic signed [XLEN-1:0] sext32(input logic signed [31:0] v);
    logic signed [XLEN-1:0] r;
    for (int i = 0; i < XLEN; i++) r[i] = v[(i < 32) ? i : 31];
    return r;
  endfunction

  function automatic logic [XLEN-1:0] zext32(input logic [31:0] v);
    logic [XLEN-1:0] r;
    for (int i = 0; i < XLEN; i++) r[i] = (i < 32) ? v[(i < 32) ? i : 31] : 1'b0;
    return r;
  endfunction

  function automatic entry_t decode(input logic [31:0] instr, input logic [XLEN-1:0] pc);
    entry_t                 e;
    logic [6:0]             opc;
    logic [2:0]             f3;
    logic                   shift;
    logic signed [XLEN-1:0] imm_i;
    opc   = instr[6:0];
    f3    = instr[14:12];
    shift = (f3 == 3'b001) || (f3 == 3'b101);
    imm_i = sext32({{20{instr[31]}}, instr[31:20]});
    e     = '0;
    e.pc  = pc;
    case (opc)
      7'b0010011: begin
        if (shift) begin
          // RV64 shifts carry a 6-bit shamt; funct6/funct7 bits are dropped
          e.fmt = FMT_Z;
          e.imm = zext32({26'd0, (XLEN == 64) & instr[25], instr[24:20]});
        end else begin
          e.fmt = FMT_I;
          e.imm = imm_i;
        end
      end
      7'b0000011, 7'b1100111: begin
        e.fmt = FMT_I;
        e.imm = imm_i;
      end
      7'b0011011: begin
        if (XLEN != 64) begin
          e.illegal = 1'b1;
        end else if (shift) begin
          e.fmt = FMT_Z;
          e.imm = zext32({27'd0, instr[24:20]});
        end else begin
          e.fmt = FMT_I;
          e.imm = imm_i;
        end
      end
      7'b0100011: begin
        e.fmt = FMT_S;
        e.imm = sext32({{20{instr[31]}}, instr[31:25], instr[11:7]});
      end
      7'b1100011: begin
        e.fmt = FMT_B;
        e.imm = sext32({{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0});
      end
      7'b0110111, 7'b0010111: begin
        e.fmt = FMT_U;
        e.imm = sext32({instr[31:12], 12'd0});
      end
      7'b1101111: begin
        e.fmt = FMT_J;
        e.imm = sext32({{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0});
      end
      7'b1110011: begin
        if ((ZICSR != 0) && f3[2]) begin
          e.fmt = FMT_Z;
          e.imm = zext32({27'd0, instr[19:15]});
        end else begin
          e.fmt = FMT_I;
          e.imm = imm_i;
        end
      end
      7'b0110011, 7'b0111011, 7'b0001111: e.fmt = FMT_NONE;
      default: e.illegal = 1'b1;
    endcase
    if (e.fmt == FMT_B || e.fmt == FMT_J || opc == 7'b0010111) e.target = pc + e.imm;
    return e;
  endfunction

  // Stage p0: combinational decode of the incoming instruction
  entry_t ent_p0;
  assign ent_p0 = decode(in_instr, in_pc);

  // Stage p1: main (presented) slot, skid slot and buffer control
  entry_t main_p1, skid_p1;
  state_t state_p1;
  logic   vld_p1, rdy_p1;
  logic   acc, deq;

  assign acc = in_valid && rdy_p1;
  assign deq = vld_p1 && out_ready;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      state_p1 <= EMPTY;
      vld_p1   <= 1'b0;
      rdy_p1   <= 1'b1;
    end else begin
      case (state_p1)
        EMPTY: if (acc) begin
          state_p1 <= ONE;
          vld_p1   <= 1'b1;
        end
        ONE: begin
          if (acc && !deq) begin
            state_p1 <= TWO;
            rdy_p1   <= 1'b0;
          end else if (deq && !acc) begin
            state_p1 <= EMPTY;
            vld_p1   <= 1'b0;
          end
        end
        TWO: if (deq) begin
          state_p1 <= ONE;
          rdy_p1   <= 1'b1;
        end
        default: begin
          state_p1 <= EMPTY;
          vld_p1   <= 1'b0;
          rdy_p1   <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state_p1 == TWO) begin
      if (deq) main_p1 <= skid_p1;
    end else if (acc && (state_p1 == EMPTY || deq)) begin
      main_p1 <= ent_p0;
    end else if (acc) begin
      skid_p1 <= ent_p0;
    end
  end

  // Data slots carry no reset; gating with valid gives zero outputs when nothing is held
  assign in_ready    = rdy_p1;
  assign out_valid   = vld_p1;
  assign out_imm     = vld_p1 ? main_p1.imm     : '0;
  assign out_fmt     = vld_p1 ? main_p1.fmt     : FMT_NONE;
  assign out_illegal = vld_p1 & main_p1.illegal;
  assign out_pc      = vld_p1 ? main_p1.pc      : '0;
  assign out_target  = vld_p1 ? main_p1.target  : '0;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: three parameter variants driven in lockstep, checked against
// a queue-based FIFO model and an arithmetic immediate reference.
module tb_imm_gen_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, flush, in_valid, out_ready;
  logic [31:0] in_instr;
  logic [63:0] in_pc;

  logic        a_rdy, a_vld, a_ill;
  logic [31:0] a_imm, a_pc, a_tgt;
  logic [2:0]  a_fmt;
  logic        b_rdy, b_vld, b_ill;
  logic [63:0] b_imm, b_pc, b_tgt;
  logic [2:0]  b_fmt;
  logic        c_rdy, c_vld, c_ill;
  logic [31:0] c_imm, c_pc, c_tgt;
  logic [2:0]  c_fmt;

  imm_gen_pipe #(.XLEN(32), .ZICSR(1)) dut_a (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(a_rdy),
    .in_instr(in_instr), .in_pc(in_pc[31:0]), .out_valid(a_vld), .out_ready(out_ready),
    .out_imm(a_imm), .out_fmt(a_fmt), .out_illegal(a_ill), .out_pc(a_pc), .out_target(a_tgt));

  imm_gen_pipe #(.XLEN(64), .ZICSR(1)) dut_b (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(b_rdy),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(b_vld), .out_ready(out_ready),
    .out_imm(b_imm), .out_fmt(b_fmt), .out_illegal(b_ill), .out_pc(b_pc), .out_target(b_tgt));

  imm_gen_pipe #(.XLEN(32), .ZICSR(0)) dut_c (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(c_rdy),
    .in_instr(in_instr), .in_pc(in_pc[31:0]), .out_valid(c_vld), .out_ready(out_ready),
    .out_imm(c_imm), .out_fmt(c_fmt), .out_illegal(c_ill), .out_pc(c_pc), .out_target(c_tgt));

  typedef struct {
    logic [31:0] ins;
    logic [63:0] pc;
  } txn_t;

  txn_t q[$];
  int   checks = 0;
  int   failures = 0;
  logic [6:0] ops [0:15] = '{7'h13, 7'h03, 7'h67, 7'h1B, 7'h23, 7'h63, 7'h37, 7'h17,
                             7'h6F, 7'h73, 7'h33, 7'h3B, 7'h0F, 7'h7F, 7'h00, 7'h0B};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Immediates rebuilt from field weights and arithmetic shifts of the signed word
  function automatic void ref_dec(input logic [31:0] ins, input logic [63:0] pc,
                                  input int xlen, input bit zicsr,
                                  output logic [63:0] imm, output logic [2:0] fmt,
                                  output logic ill, output logic [63:0] tgt);
    logic [63:0] mask;
    bit          sh;
    longint      v;
    mask = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    sh   = (ins[14:12] == 3'd1) || (ins[14:12] == 3'd5);
    v    = 0;
    fmt  = 3'd0;
    ill  = 1'b0;
    case (ins[6:0])
      7'h13: if (sh) begin fmt = 3'd6; v = longint'(ins[25:20]) % xlen; end
             else begin fmt = 3'd1; v = $signed(ins) >>> 20; end
      7'h03, 7'h67: begin fmt = 3'd1; v = $signed(ins) >>> 20; end
      7'h1B: if (xlen == 32) ill = 1'b1;
             else if (sh) begin fmt = 3'd6; v = longint'(ins[24:20]); end
             else begin fmt = 3'd1; v = $signed(ins) >>> 20; end
      7'h23: begin fmt = 3'd2; v = $signed(ins) >>> 25; v = v * 32 + longint'(ins[11:7]); end
      7'h63: begin
        fmt = 3'd3;
        v = $signed(ins) >>> 31;
        v = v * 4096 + longint'(ins[7]) * 2048 + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
      end
      7'h37, 7'h17: begin fmt = 3'd4; v = $signed(ins) >>> 12; v = v * 4096; end
      7'h6F: begin
        fmt = 3'd5;
        v = $signed(ins) >>> 31;
        v = v * 1048576 + longint'(ins[19:12]) * 4096 + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
      end
      7'h73: if (zicsr && ins[14]) begin fmt = 3'd6; v = longint'(ins[19:15]); end
             else begin fmt = 3'd1; v = $signed(ins) >>> 20; end
      7'h33, 7'h3B, 7'h0F: fmt = 3'd0;
      default: ill = 1'b1;
    endcase
    imm = 64'(v) & mask;
    tgt = (fmt == 3'd3 || fmt == 3'd5 || ins[6:0] == 7'h17) ? ((pc + 64'(v)) & mask) : 64'd0;
  endfunction

  task automatic chk_dut(input string n, input int xlen, input bit zicsr,
                         input logic rdy, input logic vld, input logic [63:0] imm,
                         input logic [2:0] fmt, input logic ill,
                         input logic [63:0] pc, input logic [63:0] tgt);
    logic [63:0] e_imm, e_tgt, mask;
    logic [2:0]  e_fmt;
    logic        e_ill;
    mask = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    chk({n, "_in_ready"}, 64'(rdy), 64'(q.size() < 2));
    chk({n, "_out_valid"}, 64'(vld), 64'(q.size() > 0));
    if (q.size() > 0) begin
      ref_dec(q[0].ins, q[0].pc, xlen, zicsr, e_imm, e_fmt, e_ill, e_tgt);
      chk({n, "_imm"}, imm, e_imm);
      chk({n, "_fmt"}, 64'(fmt), 64'(e_fmt));
      chk({n, "_illegal"}, 64'(ill), 64'(e_ill));
      chk({n, "_pc"}, pc, q[0].pc & mask);
      chk({n, "_target"}, tgt, e_tgt);
    end
  endtask

  task automatic cycle();
    bit acc, deq;
    acc = in_valid && (q.size() < 2);
    deq = (q.size() > 0) && out_ready;
    @(posedge clk);
    #1;
    if (reset || flush) q.delete();
    else begin
      if (deq) void'(q.pop_front());
      if (acc) q.push_back('{in_instr, in_pc});
    end
    chk_dut("a", 32, 1'b1, a_rdy, a_vld, 64'(a_imm), a_fmt, a_ill, 64'(a_pc), 64'(a_tgt));
    chk_dut("b", 64, 1'b1, b_rdy, b_vld, b_imm, b_fmt, b_ill, b_pc, b_tgt);
    chk_dut("c", 32, 1'b0, c_rdy, c_vld, 64'(c_imm), c_fmt, c_ill, 64'(c_pc), 64'(c_tgt));
  endtask

  task automatic send(input logic [31:0] ins, input logic [63:0] pc);
    in_valid  = 1'b1;
    in_instr  = ins;
    in_pc     = pc;
    out_ready = 1'b1;
    cycle();
    in_valid  = 1'b0;
  endtask

  task automatic chk_zero_a(input string tag);
    chk({tag, "_vld"}, 64'(a_vld), 64'd0);
    chk({tag, "_rdy"}, 64'(a_rdy), 64'd1);
    chk({tag, "_imm"}, 64'(a_imm), 64'd0);
    chk({tag, "_fmt"}, 64'(a_fmt), 64'd0);
    chk({tag, "_ill"}, 64'(a_ill), 64'd0);
    chk({tag, "_pc"}, 64'(a_pc), 64'd0);
    chk({tag, "_tgt"}, 64'(a_tgt), 64'd0);
  endtask

  initial begin
    logic [31:0] r;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_instr = 32'd0; in_pc = 64'd0;
    cycle();
    cycle();
    chk_zero_a("reset");
    reset = 1'b0;

    send(32'hFFF0_0093, 64'h0);
    chk("addi_imm", 64'(a_imm), 64'hFFFF_FFFF); chk("addi_fmt", 64'(a_fmt), 64'd1);
    send(32'h0020_A423, 64'h4);
    chk("sw_imm", 64'(a_imm), 64'h8); chk("sw_fmt", 64'(a_fmt), 64'd2);
    send(32'h1234_52B7, 64'h8);
    chk("lui_imm", 64'(a_imm), 64'h1234_5000); chk("lui_fmt", 64'(a_fmt), 64'd4);
    send(32'hFE00_0EE3, 64'h100);
    chk("beq_imm", 64'(a_imm), 64'hFFFF_FFFC); chk("beq_fmt", 64'(a_fmt), 64'd3);
    chk("beq_tgt", 64'(a_tgt), 64'hFC);
    send(32'h0010_00EF, 64'h1000);
    chk("jal_imm", 64'(a_imm), 64'h800); chk("jal_fmt", 64'(a_fmt), 64'd5);
    chk("jal_tgt", 64'(a_tgt), 64'h1800);
    send(32'h01F0_9093, 64'h0);
    chk("slli32_imm", 64'(a_imm), 64'd31); chk("slli32_fmt", 64'(a_fmt), 64'd6);
    send(32'h43F0_D093, 64'h0);
    chk("srai64_imm", b_imm, 64'd63); chk("srai64_fmt", 64'(b_fmt), 64'd6);
    send(32'h3002_D073, 64'h0);
    chk("csr_z_imm", 64'(a_imm), 64'd5); chk("csr_z_fmt", 64'(a_fmt), 64'd6);
    chk("csr_i_imm", 64'(c_imm), 64'h300); chk("csr_i_fmt", 64'(c_fmt), 64'd1);
    send(32'h0000_007F, 64'h0);
    chk("ill_flag", 64'(a_ill), 64'd1); chk("ill_imm", 64'(a_imm), 64'd0);
    send(32'h0000_001B, 64'h0);
    chk("w32_ill", 64'(a_ill), 64'd1);
    chk("w64_ill", 64'(b_ill), 64'd0); chk("w64_fmt", 64'(b_fmt), 64'd1);
    cycle();

    // Backpressure: A and B fill the buffer, C waits
    out_ready = 1'b0; in_valid = 1'b1;
    in_instr = 32'h0010_0093; in_pc = 64'hA0; cycle();
    in_instr = 32'h0020_0093; in_pc = 64'hB0; cycle();
    chk("bp_full_rdy", 64'(a_rdy), 64'd0);
    in_instr = 32'h0030_0093; in_pc = 64'hC0; cycle();
    chk("bp_held_rdy", 64'(a_rdy), 64'd0); chk("bp_pc_a", 64'(a_pc), 64'hA0);
    out_ready = 1'b1; cycle();
    chk("bp_pc_b", 64'(a_pc), 64'hB0);
    cycle();
    chk("bp_pc_c", 64'(a_pc), 64'hC0); chk("bp_vld_c", 64'(a_vld), 64'd1);
    in_valid = 1'b0; cycle();
    chk("bp_drained", 64'(a_vld), 64'd0);

    // Flush in TWO with a concurrent entry
    out_ready = 1'b0; in_valid = 1'b1;
    in_instr = 32'h0040_0093; in_pc = 64'hD0; cycle();
    in_instr = 32'h0050_0093; in_pc = 64'hD4; cycle();
    flush = 1'b1; in_instr = 32'h0060_0093; in_pc = 64'hE0; cycle();
    chk("flush_vld", 64'(a_vld), 64'd0); chk("flush_rdy", 64'(a_rdy), 64'd1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; cycle();
    chk("flush_gone", 64'(a_vld), 64'd0);

    // Reset while holding one entry
    in_valid = 1'b1; out_ready = 1'b0; in_instr = 32'hFFF0_0093; in_pc = 64'hF0; cycle();
    chk("one_vld", 64'(a_vld), 64'd1);
    in_valid = 1'b0; reset = 1'b1; cycle();
    chk_zero_a("midreset");
    reset = 1'b0;

    for (int i = 0; i < 600; i++) begin
      r         = $urandom;
      in_instr  = {r[31:7], ops[$urandom_range(0, 15)]};
      in_pc     = {$urandom, $urandom};
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      reset     = ($urandom_range(0, 99) == 0);
      cycle();
    end
    flush = 1'b0; reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    cycle();
    cycle();
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Parametrised, registered successor to the single-cycle immediate generator, for the pipelined RV32I/RV64I core's decode stage.
- Decodes the immediate, its format code and an illegal-opcode flag from a 32-bit instruction.
- Computes the PC-relative target (pc + imm) for branch, JAL and AUIPC.
- Uses a valid/ready handshake with a 2-entry skid buffer and supports a pipeline flush.

Parameters:
- XLEN, 32, datapath width; legal values are 32 and 64.
- ZICSR, 1, when 1, CSR-immediate forms produce zimm; when 0, opcode 1110011 decodes as plain I-type.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous kill of all buffered entries.
- in_valid  in  1  input entry valid.
- in_ready  out  1  block can accept an entry this cycle.
- in_instr  in  32  instruction word.
- in_pc  in  XLEN  PC of the instruction.
- out_valid  out  1  output entry valid.
- out_ready  in  1  consumer accepts the output entry this cycle.
- out_imm  out  XLEN  sign- or zero-extended immediate.
- out_fmt  out  3  format code: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z (shamt/zimm).
- out_illegal  out  1  opcode not recognised.
- out_pc  out  XLEN  in_pc passed through.
- out_target  out  XLEN  out_pc + out_imm, modulo 2^XLEN, for fmt B, J and AUIPC; 0 otherwise.

Behaviour:
- Handshakes: input transfer when in_valid && in_ready; output transfer when out_valid && out_ready. Latency is 1 cycle: an entry accepted in cycle N is presented in cycle N+1 at the earliest.
- Decode is combinational on the input; results are stored together with the pc.
- Opcode decode:
  - 0010011, 0000011, 1100111: I-type, sign-extended instr[31:20].
  - 0010011 with funct3 001 or 101: Z format, zero-extended shamt. Shamt is instr[24:20] for XLEN=32 and instr[25:20] for XLEN=64; funct7/funct6 bits are dropped.
  - 0011011 (only when XLEN=64): I-type, or Z format with a 5-bit shamt for shifts. When XLEN=32 this opcode is illegal.
  - 0100011: S-type, {instr[31:25], instr[11:7]}, sign-extended.
  - 1100011: B-type, {instr[31], instr[7], instr[30:25], instr[11:8], 0}, sign-extended.
  - 0110111, 0010111: U-type, {instr[31:12], 12'b0}, sign-extended to XLEN.
  - 1101111: J-type, {instr[31], instr[19:12], instr[20], instr[30:21], 0}, sign-extended.
  - 1110011 with ZICSR=1 and funct3[2]=1: Z format, zero-extended instr[19:15].
  - 1110011 otherwise: I-type.
  - 0110011, 0111011, 0001111: NONE, imm 0, not illegal.
  - Any other opcode: out_illegal=1, fmt NONE, imm 0, target 0.
- Buffer state machine, with the stored entries as the two buffer slots:
  - EMPTY: out_valid=0, in_ready=1.
  - ONE: out_valid=1, in_ready=1.
  - TWO: out_valid=1, in_ready=0.
- Transitions:
  - EMPTY: accept goes to ONE.
  - ONE: accept without output transfer goes to TWO (skid slot loaded). Output transfer without accept goes to EMPTY. Simultaneous accept and output transfer stays in ONE, with the main slot reloaded.
  - TWO: output transfer moves the skid slot into the main slot and goes to ONE.
- in_ready is a registered function of state only; it never depends combinationally on out_ready.
- Order is strictly FIFO; no entry is duplicated or dropped.
- flush: next state EMPTY regardless of in_valid/out_ready; an entry presented in the same cycle is discarded. flush has priority over all transfers.
- reset: same effect as flush. Reset values: out_valid=0, in_ready=1, out_imm=0, out_fmt=0, out_illegal=0, out_pc=0, out_target=0.
- Reset asserted mid-operation discards all stored entries.
- Data outputs hold stable while out_valid=1 and out_ready=0.

Test Plan:
- XLEN=32, one entry each, out_ready=1:
  - 0xFFF00093 gives imm 0xFFFFFFFF, fmt 1.
  - 0x0020A423 gives imm 0x00000008, fmt 2.
  - 0x123452B7 gives imm 0x12345000, fmt 4.
  - Each appears exactly one cycle after acceptance.
- Branch/jump targets:
  - 0xFE000EE3 at pc 0x100 gives imm 0xFFFFFFFC, fmt 3, target 0x000000FC.
  - 0x001000EF at pc 0x1000 gives imm 0x800, fmt 5, target 0x1800.
- Shifts and CSR:
  - XLEN=32, 0x01F09093 gives imm 31, fmt 6.
  - XLEN=64, 0x43F0D093 gives imm 63, fmt 6.
  - ZICSR=1, 0x3002D073 gives imm 5, fmt 6.
  - ZICSR=0, 0x3002D073 gives imm 0x300, fmt 1.
- Backpressure:
  - Stimulus: out_ready=0, in_valid=1 with entries A, B, C on consecutive cycles.
  - A and B are accepted; in_ready goes 0 and C is held.
  - Raising out_ready gives outputs A, B, C in order, with no gaps once steady.
- Flush:
  - Stimulus: state TWO, flush=1 with in_valid=1 in the same cycle.
  - Next cycle: out_valid=0, in_ready=1, and the concurrent entry never appears.
  - Assert reset in state ONE: same result, with all outputs 0.
- Illegal opcodes:
  - 0x0000007F gives out_illegal=1, imm 0.
  - XLEN=32, 0x0000001B gives out_illegal=1.
  - XLEN=64, 0x0000001B gives out_illegal=0, fmt 1.
